// File: rtl/alu_muldiv.sv
// alu_muldiv: registered MIPS execute-stage ALU with a valid/ready handshake.
// Single-cycle R-type ops are registered on accept. When the macro
// ALU_MULDIV_EN is defined, the unit adds an iterative radix-2 mul/div with
// architectural HI/LO registers. Without the macro those funct codes decode
// as illegal, and o_ready is tied high.
module alu_muldiv #(
   parameter int N_BITS  = 32,
   parameter int SH_BITS = $clog2(N_BITS)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [5:0]         i_op,
   input  logic [N_BITS-1:0]  i_a,
   input  logic [N_BITS-1:0]  i_b,
   input  logic [SH_BITS-1:0] i_shamt,
   output logic               o_valid,
   output logic [N_BITS-1:0]  o_o,
   output logic               o_overflow,
   output logic               o_illegal
);
   localparam logic [5:0] F_SLL   = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
   localparam logic [5:0] F_SLLV  = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
   localparam logic [5:0] F_ADD   = 6'b100000, F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010, F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100, F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110, F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010, F_SLTU = 6'b101011;
`ifdef ALU_MULDIV_EN
   localparam logic [5:0] F_MFHI  = 6'b010000, F_MTHI = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010, F_MTLO = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000, F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010, F_DIVU  = 6'b011011;

   logic [N_BITS-1:0] hi, lo;
`endif

   logic [N_BITS-1:0]  sum, diff, res_sc;
   logic [SH_BITS-1:0] vamt;
   logic               ovf_sc, ill_sc, accept;

   assign sum  = i_a + i_b;
   assign diff = i_a - i_b;
   assign vamt = i_a[SH_BITS-1:0];

   // single-cycle result decode; unknown funct yields zero and illegal
   always_comb begin
      res_sc = '0;
      ovf_sc = 1'b0;
      ill_sc = 1'b0;
      case (i_op)
         F_ADD:  begin
            res_sc = sum;
            ovf_sc = (i_a[N_BITS-1] == i_b[N_BITS-1]) && (sum[N_BITS-1] != i_a[N_BITS-1]);
         end
         F_ADDU: res_sc = sum;
         F_SUB:  begin
            res_sc = diff;
            ovf_sc = (i_a[N_BITS-1] != i_b[N_BITS-1]) && (diff[N_BITS-1] != i_a[N_BITS-1]);
         end
         F_SUBU: res_sc = diff;
         F_AND:  res_sc = i_a & i_b;
         F_OR:   res_sc = i_a | i_b;
         F_XOR:  res_sc = i_a ^ i_b;
         F_NOR:  res_sc = ~(i_a | i_b);
         F_SLT:  res_sc = N_BITS'($signed(i_a) < $signed(i_b));
         F_SLTU: res_sc = N_BITS'(i_a < i_b);
         F_SLL:  res_sc = i_b << i_shamt;
         F_SRL:  res_sc = i_b >> i_shamt;
         F_SRA:  res_sc = $signed(i_b) >>> i_shamt;
         F_SLLV: res_sc = i_b << vamt;
         F_SRLV: res_sc = i_b >> vamt;
         F_SRAV: res_sc = $signed(i_b) >>> vamt;
`ifdef ALU_MULDIV_EN
         F_MFHI: res_sc = hi;
         F_MFLO: res_sc = lo;
         F_MTHI, F_MTLO: res_sc = i_a;
         F_MULT, F_MULTU, F_DIV, F_DIVU: res_sc = '0;
`endif
         default: ill_sc = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t              state;
   logic [SH_BITS-1:0]  cnt;
   logic [2*N_BITS-1:0] acc, acc_nxt, prod;
   logic [N_BITS-1:0]   mop, a_mag, b_mag, q, r, fin_hi, fin_lo;
   logic [N_BITS:0]     madd, trial;
   logic                rdy, neg_lo, neg_hi, dz, sgn, is_mul, is_div;

   assign is_mul  = (i_op == F_MULT) || (i_op == F_MULTU);
   assign is_div  = (i_op == F_DIV)  || (i_op == F_DIVU);
   assign sgn     = ~i_op[0];
   assign a_mag   = (sgn && i_a[N_BITS-1]) ? -i_a : i_a;
   assign b_mag   = (sgn && i_b[N_BITS-1]) ? -i_b : i_b;
   assign accept  = i_valid && rdy;
   assign o_ready = rdy;

   // one radix-2 step (shift-add for MUL, restoring subtract for DIV) plus the
   // sign-corrected final HI/LO, so the last step can commit at its own edge
   always_comb begin
      madd    = {1'b0, acc[2*N_BITS-1:N_BITS]} + (acc[0] ? {1'b0, mop} : '0);
      trial   = acc[2*N_BITS-1:N_BITS-1] - {1'b0, mop};
      acc_nxt = acc;
      if (state == MUL)
         acc_nxt = {madd, acc[N_BITS-1:1]};
      else if (state == DIV)
         acc_nxt = trial[N_BITS] ? {acc[2*N_BITS-2:0], 1'b0}
                                 : {trial[N_BITS-1:0], acc[N_BITS-2:0], 1'b1};
      prod = neg_lo ? -acc_nxt : acc_nxt;
      q    = acc_nxt[N_BITS-1:0];
      r    = acc_nxt[2*N_BITS-1:N_BITS];
      if (state == MUL) begin
         fin_hi = prod[2*N_BITS-1:N_BITS];
         fin_lo = prod[N_BITS-1:0];
      end else begin
         // divide by zero: quotient forced to all ones, remainder is the dividend
         fin_hi = neg_hi ? -r : r;
         fin_lo = dz ? '1 : (neg_lo ? -q : q);
      end
   end

   // control FSM: accepts in IDLE/DONE, iterates N_BITS steps in MUL/DIV
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         rdy        <= 1'b1;
         cnt        <= '0;
         acc        <= '0;
         mop        <= '0;
         neg_lo     <= 1'b0;
         neg_hi     <= 1'b0;
         dz         <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         o_valid    <= 1'b0;
         o_o        <= '0;
         o_overflow <= 1'b0;
         o_illegal  <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            MUL, DIV: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == SH_BITS'(N_BITS - 1)) begin
                  state      <= DONE;
                  rdy        <= 1'b1;
                  hi         <= fin_hi;
                  lo         <= fin_lo;
                  o_valid    <= 1'b1;
                  o_o        <= fin_lo;
                  o_overflow <= 1'b0;
                  o_illegal  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               if (accept) begin
                  if (is_mul) begin
                     state  <= MUL;
                     rdy    <= 1'b0;
                     cnt    <= '0;
                     acc    <= {{N_BITS{1'b0}}, b_mag};
                     mop    <= a_mag;
                     neg_lo <= sgn && (i_a[N_BITS-1] ^ i_b[N_BITS-1]);
                     neg_hi <= 1'b0;
                     dz     <= 1'b0;
                  end else if (is_div) begin
                     state  <= DIV;
                     rdy    <= 1'b0;
                     cnt    <= '0;
                     acc    <= {{N_BITS{1'b0}}, a_mag};
                     mop    <= b_mag;
                     neg_lo <= sgn && (i_a[N_BITS-1] ^ i_b[N_BITS-1]);
                     neg_hi <= sgn && i_a[N_BITS-1];
                     dz     <= (i_b == '0);
                  end else begin
                     o_valid    <= 1'b1;
                     o_o        <= res_sc;
                     o_overflow <= ovf_sc;
                     o_illegal  <= ill_sc;
                     if (i_op == F_MTHI) hi <= i_a;
                     if (i_op == F_MTLO) lo <= i_a;
                  end
               end
            end
         endcase
      end
   end
`else
   assign o_ready = 1'b1;
   assign accept  = i_valid;

   // register single-cycle results on every accept
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid    <= 1'b0;
         o_o        <= '0;
         o_overflow <= 1'b0;
         o_illegal  <= 1'b0;
      end else begin
         o_valid <= accept;
         if (accept) begin
            o_o        <= res_sc;
            o_overflow <= ovf_sc;
            o_illegal  <= ill_sc;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed + randomised scoreboard bench for alu_muldiv.
// Mul/div/HI/LO steps are compiled in only when ALU_MULDIV_EN is defined;
// otherwise those funct codes are checked as illegal single-cycle ops.
module tb_alu_muldiv;
   localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
   localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
   localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;
   localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
   localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
   localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic [5:0]  i_op = '0;
   logic [31:0] i_a = '0, i_b = '0;
   logic [4:0]  i_shamt = '0;
   logic        o_ready, o_valid, o_overflow, o_illegal;
   logic [31:0] o_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic        ovf;
      logic        ill;
      int          lat;
      int          rlow;
   } exp_t;

   exp_t sb[$];

   alu_muldiv #(.N_BITS(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_shamt(i_shamt),
      .o_valid(o_valid), .o_o(o_o), .o_overflow(o_overflow), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference for the single-cycle function set
   function automatic void sc_model(input logic [5:0] op, input logic [31:0] a, b,
                                    input logic [4:0] sh, output logic [31:0] r,
                                    output logic ovf, output logic ill);
      longint w;
      r = '0; ovf = 1'b0; ill = 1'b0; w = 0;
      case (op)
         F_ADD:  begin r = a + b; w = longint'($signed(a)) + longint'($signed(b)); ovf = (w != longint'($signed(r))); end
         F_ADDU: r = a + b;
         F_SUB:  begin r = a - b; w = longint'($signed(a)) - longint'($signed(b)); ovf = (w != longint'($signed(r))); end
         F_SUBU: r = a - b;
         F_AND:  r = a & b;
         F_OR:   r = a | b;
         F_XOR:  r = a ^ b;
         F_NOR:  r = ~(a | b);
         F_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         F_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         F_SLL:  r = b << sh;
         F_SRL:  r = b >> sh;
         F_SRA:  r = $signed(b) >>> sh;
         F_SLLV: r = b << a[4:0];
         F_SRLV: r = b >> a[4:0];
         F_SRAV: r = $signed(b) >>> a[4:0];
         default: ill = 1'b1;
      endcase
   endfunction

   // drive one request for one edge and push its expected result
   task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] a, b,
                        input logic [4:0] sh, input logic [31:0] res, input logic ovf, ill,
                        input int lat, input int rlow);
      exp_t e;
      chk({tag, "_rdy"}, {63'd0, o_ready}, 64'd1);
      e.tag = tag; e.res = res; e.ovf = ovf; e.ill = ill; e.lat = lat; e.rlow = rlow;
      sb.push_back(e);
      i_op = op; i_a = a; i_b = b; i_shamt = sh; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   // wait (bounded) for o_valid, then pop and compare
   task automatic collect();
      exp_t e;
      int n, rlow;
      n = 1; rlow = 0;
      while (!o_valid && n < 200) begin
         if (!o_ready) rlow++;
         @(posedge i_clk); #1;
         n++;
      end
      chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      chk({e.tag, "_lat"},  64'(n),    64'(e.lat));
      chk({e.tag, "_rlow"}, 64'(rlow), 64'(e.rlow));
      chk({e.tag, "_o"},    {32'd0, o_o}, {32'd0, e.res});
      chk({e.tag, "_ovf"},  {63'd0, o_overflow}, {63'd0, e.ovf});
      chk({e.tag, "_ill"},  {63'd0, o_illegal},  {63'd0, e.ill});
   endtask

   task automatic sc(input string tag, input logic [5:0] op, input logic [31:0] a, b,
                     input logic [4:0] sh, input logic [31:0] res, input logic ovf, ill);
      issue(tag, op, a, b, sh, res, ovf, ill, 1, 0);
      collect();
   endtask

   initial begin
      logic [5:0]  ops [16];
      logic [31:0] r;
      logic        ov, il;
      ops = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
              F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV};

      // reset state
      #2;
      chk("rst_ready", {63'd0, o_ready}, 64'd1);
      chk("rst_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_o",     {32'd0, o_o}, 64'd0);
      chk("rst_ovf",   {63'd0, o_overflow}, 64'd0);
      chk("rst_ill",   {63'd0, o_illegal}, 64'd0);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      // overflow and back-to-back accepts
      issue("add_ovf", F_ADD, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b1, 1'b0, 1, 0);
      collect();
      issue("addu", F_ADDU, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b0, 1'b0, 1, 0);
      collect();
      @(posedge i_clk); #1;
      chk("valid_one_cycle", {63'd0, o_valid}, 64'd0);
      sc("sub_ovf", F_SUB, 32'h80000000, 32'd1, 5'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
      sc("sub_nov", F_SUB, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0);

      // shifts, compares, logic
      sc("sra",   F_SRA,  32'd0, 32'hF0000000, 5'd4, 32'hFF000000, 1'b0, 1'b0);
      sc("srlv",  F_SRLV, 32'd36, 32'h80000000, 5'd0, 32'h08000000, 1'b0, 1'b0);
      sc("sltu",  F_SLTU, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd1, 1'b0, 1'b0);
      sc("slt",   F_SLT,  32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b0, 1'b0);
      sc("sll31", F_SLL,  32'd0, 32'h00000003, 5'd31, 32'h80000000, 1'b0, 1'b0);
      sc("srav",  F_SRAV, 32'd33, 32'h80000000, 5'd0, 32'hC0000000, 1'b0, 1'b0);
      sc("nor",   F_NOR,  32'h0F0F0000, 32'h000000F0, 5'd0, 32'hF0F0FF0F, 1'b0, 1'b0);
      sc("illegal", 6'b111111, 32'hDEADBEEF, 32'h1, 5'd3, 32'd0, 1'b0, 1'b1);

      // random single-cycle ops against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [5:0]  op;
         logic [31:0] a, b;
         logic [4:0]  sh;
         op = ops[$urandom_range(0, 15)];
         a = $urandom; b = $urandom; sh = 5'($urandom_range(0, 31));
         sc_model(op, a, b, sh, r, ov, il);
         sc($sformatf("rnd%0d", i), op, a, b, sh, r, ov, il);
      end

`ifdef ALU_MULDIV_EN
      // multiply, with MFHI accepted in the completion cycle
      issue("mult", F_MULT, 32'hFFFFFFFE, 32'd3, 5'd0, 32'hFFFFFFFA, 1'b0, 1'b0, 33, 32);
      collect();
      sc("mfhi_b2b", F_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
      sc("mflo", F_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFA, 1'b0, 1'b0);
      issue("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 1'b0, 1'b0, 33, 32);
      collect();
      sc("multu_hi", F_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0);

      // divide corner cases
      issue("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, 5'd0, 32'hFFFFFFFD, 1'b0, 1'b0, 33, 32);
      collect();
      sc("div_neg_hi", F_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
      issue("divu_z", F_DIVU, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 32);
      collect();
      sc("divu_z_hi", F_MFHI, 32'd0, 32'd0, 5'd0, 32'd5, 1'b0, 1'b0);
      issue("div_z_neg", F_DIV, 32'hFFFFFFF7, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 32);
      collect();
      sc("div_z_neg_hi", F_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFFFFF7, 1'b0, 1'b0);
      issue("div_mn", F_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b0, 1'b0, 33, 32);
      collect();
      sc("div_mn_hi", F_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);

      // random signed mul/div against integer arithmetic
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, b, lo_e, hi_e;
         longint      p;
         a = $urandom; b = $urandom;
         p = longint'($signed(a)) * longint'($signed(b));
         lo_e = p[31:0]; hi_e = p[63:32];
         issue($sformatf("rmul%0d", i), F_MULT, a, b, 5'd0, lo_e, 1'b0, 1'b0, 33, 32);
         collect();
         sc($sformatf("rmul%0d_hi", i), F_MFHI, 32'd0, 32'd0, 5'd0, hi_e, 1'b0, 1'b0);
         b = 32'($urandom_range(1, 5000));
         if (i[0]) b = -b;
         lo_e = 32'($signed(a) / $signed(b));
         hi_e = 32'($signed(a) % $signed(b));
         issue($sformatf("rdiv%0d", i), F_DIV, a, b, 5'd0, lo_e, 1'b0, 1'b0, 33, 32);
         collect();
         sc($sformatf("rdiv%0d_hi", i), F_MFHI, 32'd0, 32'd0, 5'd0, hi_e, 1'b0, 1'b0);
      end

      // move-to followed immediately by move-from
      sc("mthi", F_MTHI, 32'h12345678, 32'd0, 5'd0, 32'h12345678, 1'b0, 1'b0);
      sc("mfhi_fwd", F_MFHI, 32'd0, 32'd0, 5'd0, 32'h12345678, 1'b0, 1'b0);
      sc("mtlo", F_MTLO, 32'hCAFEF00D, 32'd0, 5'd0, 32'hCAFEF00D, 1'b0, 1'b0);
      sc("mflo_fwd", F_MFLO, 32'd0, 32'd0, 5'd0, 32'hCAFEF00D, 1'b0, 1'b0);

      // reset in the middle of a divide
      begin
         int nv;
         i_op = F_DIV; i_a = 32'd100; i_b = 32'd7; i_valid = 1'b1;
         @(posedge i_clk); #1;
         i_valid = 1'b0;
         repeat (9) @(posedge i_clk);
         #1;
         chk("div_busy", {63'd0, o_ready}, 64'd0);
         i_rst_n = 1'b0;
         #1;
         chk("abort_ready", {63'd0, o_ready}, 64'd1);
         chk("abort_valid", {63'd0, o_valid}, 64'd0);
         @(posedge i_clk); #1;
         i_rst_n = 1'b1;
         nv = 0;
         repeat (40) begin
            @(posedge i_clk); #1;
            if (o_valid) nv++;
         end
         chk("abort_no_valid", 64'(nv), 64'd0);
         sc("abort_mflo", F_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
         sc("abort_mfhi", F_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
      end
`else
      // mul/div/HI/LO codes decode as illegal single-cycle ops
      sc("nomd_mult", F_MULT,  32'd3, 32'd4, 5'd0, 32'd0, 1'b0, 1'b1);
      sc("nomd_divu", F_DIVU,  32'd9, 32'd3, 5'd0, 32'd0, 1'b0, 1'b1);
      sc("nomd_mthi", F_MTHI,  32'd7, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
      sc("nomd_mflo", F_MFLO,  32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
      sc("nomd_add",  F_ADDU,  32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge i_clk); #1;
         chk($sformatf("nomd_ready%0d", i), {63'd0, o_ready}, 64'd1);
      end
`endif

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
